// File: rtl/bubble_sort_engine.sv
// In-place bubble sort of DEPTH words held in a single-port, sync-read RAM.
// Signed or unsigned keys, runtime sort direction, early exit, swap/pass statistics.
module bubble_sort_engine #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int SIGNED = 0,
  localparam int AW    = $clog2(DEPTH),
  localparam int SCW   = $clog2(DEPTH * (DEPTH - 1) / 2 + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             descend,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             done,
  output logic [SCW-1:0]   swap_count,
  output logic [AW-1:0]    pass_count
);

  // state | meaning
  // IDLE  | waiting for start
  // INIT  | clear counters and statistics, latch sort direction
  // RD_A  | read word j
  // RD_B  | capture word j, read word j+1
  // CMP   | capture word j+1, decide whether the pair is out of order
  // WR_A  | write word j+1's value to address j
  // WR_B  | write word j's value to address j+1, count the swap
  // NEXT  | advance j, or close the pass and decide on early exit
  // DONE  | one-cycle completion pulse
  typedef enum logic [3:0] {
    IDLE, INIT, RD_A, RD_B, CMP, WR_A, WR_B, NEXT, DONE
  } state_t;

  state_t           state;
  logic [AW-1:0]    i;
  logic [AW-1:0]    j;
  logic [AW-1:0]    last_j;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ord;
  logic             swapped;
  logic             a_gt;
  logic             a_lt;
  logic             swap_hit;

  // Each pass shrinks by one, so j+1 stays inside the array.
  assign last_j = AW'(DEPTH - 2) - i;

  always_comb begin
    a_gt = 1'b0;
    a_lt = 1'b0;
    if (SIGNED != 0) begin
      a_gt = $signed(a) > $signed(mem_rdata);
      a_lt = $signed(a) < $signed(mem_rdata);
    end else begin
      a_gt = a > mem_rdata;
      a_lt = a < mem_rdata;
    end
  end

  // Strict compare keeps equal keys in place.
  assign swap_hit = ord ? a_lt : a_gt;

  assign mem_addr  = (state == RD_B || state == WR_B) ? j + AW'(1) : j;
  assign mem_wdata = (state == WR_B) ? a : b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      a          <= '0;
      b          <= '0;
      ord        <= 1'b0;
      swapped    <= 1'b0;
      swap_count <= '0;
      pass_count <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= INIT;
            busy  <= 1'b1;
          end
        end
        INIT: begin
          i          <= '0;
          j          <= '0;
          swap_count <= '0;
          pass_count <= '0;
          swapped    <= 1'b0;
          ord        <= descend;
          if (DEPTH < 2) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state  <= RD_A;
            mem_rd <= 1'b1;
          end
        end
        RD_A: state <= RD_B;
        RD_B: begin
          a      <= mem_rdata;
          mem_rd <= 1'b0;
          state  <= CMP;
        end
        CMP: begin
          b <= mem_rdata;
          if (swap_hit) begin
            state  <= WR_A;
            mem_wr <= 1'b1;
          end else begin
            state <= NEXT;
          end
        end
        WR_A: state <= WR_B;
        WR_B: begin
          mem_wr     <= 1'b0;
          swap_count <= swap_count + SCW'(1);
          swapped    <= 1'b1;
          state      <= NEXT;
        end
        NEXT: begin
          if (j < last_j) begin
            j      <= j + AW'(1);
            state  <= RD_A;
            mem_rd <= 1'b1;
          end else begin
            pass_count <= pass_count + AW'(1);
            if (!swapped || i == AW'(DEPTH - 2)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              i       <= i + AW'(1);
              j       <= '0;
              swapped <= 1'b0;
              state   <= RD_A;
              mem_rd  <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Directed bench: an unsigned and a signed 8x8 sorter run side by side on identical RAM images.
module tb_bubble_sort_engine;

  logic clk = 1'b0;
  logic rst, start, descend;
  always #5 clk = ~clk;

  logic [2:0] addr0, addr1, pc0, pc1;
  logic       rd0, rd1, wr0, wr1, busy0, busy1, done0, done1;
  logic [7:0] wdata0, wdata1, rdata0, rdata1;
  logic [4:0] sc0, sc1;

  bubble_sort_engine #(.WIDTH(8), .DEPTH(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start), .descend(descend),
    .mem_addr(addr0), .mem_rd(rd0), .mem_wr(wr0), .mem_wdata(wdata0),
    .mem_rdata(rdata0), .busy(busy0), .done(done0),
    .swap_count(sc0), .pass_count(pc0));

  bubble_sort_engine #(.WIDTH(8), .DEPTH(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .descend(descend),
    .mem_addr(addr1), .mem_rd(rd1), .mem_wr(wr1), .mem_wdata(wdata1),
    .mem_rdata(rdata1), .busy(busy1), .done(done1),
    .swap_count(sc1), .pass_count(pc1));

  logic [7:0] ram0 [8];
  logic [7:0] ram1 [8];
  logic [7:0] load_vec [8];
  logic       load_go;

  always @(posedge clk) begin
    if (load_go) begin
      for (int k = 0; k < 8; k++) begin
        ram0[k] <= load_vec[k];
        ram1[k] <= load_vec[k];
      end
    end else begin
      if (wr0) ram0[addr0] <= wdata0;
      if (wr1) ram1[addr1] <= wdata1;
    end
    if (rd0) rdata0 <= ram0[addr0];
    if (rd1) rdata1 <= ram1[addr1];
  end

  logic mon_clr;
  int   wr_cnt, eq_cnt, both_cnt, dn0, dn1;

  always @(posedge clk) begin
    if (mon_clr) begin
      wr_cnt <= 0; eq_cnt <= 0; both_cnt <= 0; dn0 <= 0; dn1 <= 0;
    end else begin
      if (wr0) begin
        wr_cnt <= wr_cnt + 1;
        if (wdata0 == ram0[addr0]) eq_cnt <= eq_cnt + 1;
      end
      if ((rd0 && wr0) || (rd1 && wr1)) both_cnt <= both_cnt + 1;
      if (done0) dn0 <= dn0 + 1;
      if (done1) dn1 <= dn1 + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] d [8]);
    load_vec = d;
    @(negedge clk) load_go = 1'b1;
    @(negedge clk) load_go = 1'b0;
  endtask

  // Returns cycles from the INIT cycle (1) to the done cycle inclusive, -1 on timeout.
  task automatic run_sort(input logic desc, input int pulse_at, output int cyc0);
    int first1;
    cyc0   = -1;
    first1 = -1;
    descend = desc;
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      start = (k == pulse_at);
      if (done0 && cyc0 < 0) cyc0 = k;
      if (done1 && first1 < 0) first1 = k;
      if (cyc0 >= 0 && first1 >= 0) break;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("done_u_seen", 32'(cyc0 >= 0), 32'd1);
    check("done_s_seen", 32'(first1 >= 0), 32'd1);
  endtask

  typedef struct {
    string      name;
    logic [7:0] din   [8];
    logic       desc;
    logic [7:0] exp_u [8];
    logic [7:0] exp_s [8];
    int         swaps;
    int         passes;
    int         cycles;
    bit         no_wr;
    int         pulse_at;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cyc;
    int found;
    int inv;
    logic [7:0] snap [8];
    logic [7:0] tmp;

    vecs[0].name = "t1_asc";
    vecs[0].din   = '{8'h05, 8'h03, 8'h07, 8'h01, 8'h00, 8'hFF, 8'h02, 8'h02};
    vecs[0].desc  = 1'b0;
    vecs[0].exp_u = '{8'h00, 8'h01, 8'h02, 8'h02, 8'h03, 8'h05, 8'h07, 8'hFF};
    vecs[0].exp_s = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h02, 8'h03, 8'h05, 8'h07};
    vecs[0].swaps = 16; vecs[0].passes = 5; vecs[0].cycles = 134;
    vecs[0].no_wr = 1'b0; vecs[0].pulse_at = -1;

    vecs[1].name = "t2_sorted";
    vecs[1].din   = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    vecs[1].desc  = 1'b0;
    vecs[1].exp_u = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    vecs[1].exp_s = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    vecs[1].swaps = 0; vecs[1].passes = 1; vecs[1].cycles = 30;
    vecs[1].no_wr = 1'b1; vecs[1].pulse_at = -1;

    vecs[2].name = "t3_desc";
    vecs[2].din   = '{8'h05, 8'h03, 8'h07, 8'h01, 8'h00, 8'hFF, 8'h02, 8'h02};
    vecs[2].desc  = 1'b1;
    vecs[2].exp_u = '{8'hFF, 8'h07, 8'h05, 8'h03, 8'h02, 8'h02, 8'h01, 8'h00};
    vecs[2].exp_s = '{8'h07, 8'h05, 8'h03, 8'h02, 8'h02, 8'h01, 8'h00, 8'hFF};
    vecs[2].swaps = 11; vecs[2].passes = 6; vecs[2].cycles = -1;
    vecs[2].no_wr = 1'b0; vecs[2].pulse_at = -1;

    vecs[3].name = "t4_sign";
    vecs[3].din   = '{8'hFF, 8'h01, 8'h80, 8'h00, 8'h7F, 8'hFE, 8'h02, 8'h81};
    vecs[3].desc  = 1'b0;
    vecs[3].exp_u = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    vecs[3].exp_s = '{8'h80, 8'h81, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h7F};
    vecs[3].swaps = 14; vecs[3].passes = -1; vecs[3].cycles = -1;
    vecs[3].no_wr = 1'b0; vecs[3].pulse_at = -1;

    vecs[4].name = "t5_reverse";
    vecs[4].din   = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    vecs[4].desc  = 1'b0;
    vecs[4].exp_u = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    vecs[4].exp_s = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    vecs[4].swaps = 28; vecs[4].passes = 7; vecs[4].cycles = 170;
    vecs[4].no_wr = 1'b0; vecs[4].pulse_at = 10;

    rst = 1'b0; start = 1'b0; descend = 1'b0; load_go = 1'b0; mon_clr = 1'b1;
    #12;
    check("reset_outputs", 32'({addr0, rd0, wr0, wdata0, busy0, done0, sc0, pc0}), 32'd0);
    @(negedge clk) rst = 1'b1;

    foreach (vecs[v]) begin
      load(vecs[v].din);
      run_sort(vecs[v].desc, vecs[v].pulse_at, cyc);
      for (int k = 0; k < 8; k++) begin
        check({vecs[v].name, "_ram_u"}, 32'(ram0[k]), 32'(vecs[v].exp_u[k]));
        check({vecs[v].name, "_ram_s"}, 32'(ram1[k]), 32'(vecs[v].exp_s[k]));
      end
      check({vecs[v].name, "_swaps"}, 32'(sc0), 32'(vecs[v].swaps));
      if (vecs[v].passes >= 0) check({vecs[v].name, "_passes"}, 32'(pc0), 32'(vecs[v].passes));
      if (vecs[v].cycles >= 0) check({vecs[v].name, "_cycles"}, 32'(cyc), 32'(vecs[v].cycles));
      if (vecs[v].no_wr) check({vecs[v].name, "_no_wr"}, 32'(wr_cnt), 32'd0);
      check({vecs[v].name, "_done_u_pulses"}, 32'(dn0), 32'd1);
      check({vecs[v].name, "_done_s_pulses"}, 32'(dn1), 32'd1);
      check({vecs[v].name, "_equal_writes"}, 32'(eq_cnt), 32'd0);
      check({vecs[v].name, "_rd_wr_overlap"}, 32'(both_cnt), 32'd0);
      check({vecs[v].name, "_busy_after"}, 32'({busy0, busy1}), 32'd0);
    end

    // Abort in the middle of the first write, then re-sort whatever the RAM now holds.
    load(vecs[0].din);
    descend = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      if (wr0) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("t6_write_reached", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_wr_dropped", 32'(wr0), 32'd0);
    check("t6_busy_dropped", 32'(busy0), 32'd0);
    check("t6_rd_dropped", 32'(rd0), 32'd0);
    check("t6_counts_cleared", 32'({sc0, pc0}), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);

    snap = ram0;
    inv = 0;
    for (int p = 0; p < 8; p++)
      for (int q = p + 1; q < 8; q++)
        if (snap[p] > snap[q]) inv++;
    for (int p = 1; p < 8; p++) begin
      tmp = snap[p];
      for (int q = p - 1; q >= 0; q--) begin
        if (snap[q] > tmp) begin
          snap[q + 1] = snap[q];
          snap[q] = tmp;
        end else begin
          break;
        end
      end
    end

    run_sort(1'b0, -1, cyc);
    for (int k = 0; k < 8; k++) check("t6_ram_u", 32'(ram0[k]), 32'(snap[k]));
    check("t6_swaps", 32'(sc0), 32'(inv));
    check("t6_done_pulses", 32'(dn0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
